// File: rtl/call_stack_pkg.sv
// Shared constants for the return-address stack: default geometry and the
// 2-bit stack operation encodings decoded from {push, pop}.
package call_stack_pkg;

    localparam int STACK_DEPTH = 8;
    localparam int STACK_WIDTH = 32;

    // Encodings line up with the {push, pop} request bits.
    typedef enum logic [1:0] {
        stack_hold    = 2'b00,
        stack_pop     = 2'b01,
        stack_push    = 2'b10,
        stack_replace = 2'b11
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic push, input logic pop);
        stack_op_e op;
        case ({push, pop})
            2'b00:   op = stack_hold;
            2'b01:   op = stack_pop;
            2'b10:   op = stack_push;
            2'b11:   op = stack_replace;
            default: op = stack_hold;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/call_stack.sv
// Return-address LIFO feeding the PC block's topStack input.
// Optional sticky overflow/underflow flags under `CALL_STACK_ERR_EN.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int WIDTH = STACK_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             EN,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] pushData,
    output logic [WIDTH-1:0] topStack,
    output logic             empty,
`ifdef CALL_STACK_ERR_EN
    output logic             full,
    output logic             overflow,
    output logic             underflow
`else
    output logic             full
`endif
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [SPW-1:0]   sp_r;
    logic [SPW-1:0]   sp_nxt_s;
    logic [AW-1:0]    top_idx_s;
    logic [AW-1:0]    wr_idx_s;
    logic             wr_en_s;
    logic             empty_s;
    logic             full_s;
    stack_op_e        op_s;
`ifdef CALL_STACK_ERR_EN
    logic             overflow_r;
    logic             underflow_r;
    logic             ovf_set_s;
    logic             unf_set_s;
`endif

    assign empty_s   = (sp_r == {SPW{1'b0}});
    assign full_s    = (sp_r == SPW'(DEPTH));
    assign top_idx_s = AW'(sp_r - SPW'(1'b1));
    assign op_s      = decode_op(push, pop);

    // Next-state decode; a replace on an empty stack degrades to a plain push.
    always_comb begin
        sp_nxt_s = sp_r;
        wr_en_s  = 1'b0;
        wr_idx_s = AW'(sp_r);
`ifdef CALL_STACK_ERR_EN
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
`endif
        if (EN) begin
            case (op_s)
                stack_push: begin
                    if (full_s) begin
`ifdef CALL_STACK_ERR_EN
                        ovf_set_s = 1'b1;
`endif
                    end else begin
                        wr_en_s  = 1'b1;
                        sp_nxt_s = sp_r + SPW'(1'b1);
                    end
                end
                stack_pop: begin
                    if (empty_s) begin
`ifdef CALL_STACK_ERR_EN
                        unf_set_s = 1'b1;
`endif
                    end else begin
                        sp_nxt_s = sp_r - SPW'(1'b1);
                    end
                end
                stack_replace: begin
                    if (empty_s) begin
                        wr_en_s  = 1'b1;
                        sp_nxt_s = sp_r + SPW'(1'b1);
                    end else begin
                        wr_en_s  = 1'b1;
                        wr_idx_s = top_idx_s;
                    end
                end
                default: begin
                    sp_nxt_s = sp_r;
                end
            endcase
        end else begin
            sp_nxt_s = sp_r;
        end
    end

    // Stack pointer; reset empties the stack without touching memory.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp_r <= {SPW{1'b0}};
        end else begin
            sp_r <= sp_nxt_s;
        end
    end

`ifdef CALL_STACK_ERR_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r | ovf_set_s;
            underflow_r <= underflow_r | unf_set_s;
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`endif

    // Entry storage; no reset needed since sp gates visibility.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= pushData;
        end
    end

    // Top-of-stack read, forced to zero when empty.
    always_comb begin
        if (empty_s) begin
            topStack = {WIDTH{1'b0}};
        end else begin
            topStack = mem_r[top_idx_s];
        end
    end

    assign empty = empty_s;
    assign full  = full_s;

endmodule

// File: tb/tb_call_stack.sv
// Directed scoreboard bench for call_stack (DEPTH=8, WIDTH=32); checks the
// sticky error flags as well when built with `CALL_STACK_ERR_EN.
module tb_call_stack;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        EN = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [31:0] pushData = 32'd0;
    logic [31:0] topStack;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    typedef struct {
        logic [31:0] top;
        logic        emp;
        logic        ful;
        logic        ovf;
        logic        unf;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    call_stack #(.DEPTH(8), .WIDTH(32)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .EN       (EN),
        .push     (push),
        .pop      (pop),
        .pushData (pushData),
        .topStack (topStack),
        .empty    (empty),
`ifdef CALL_STACK_ERR_EN
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
`else
        .full     (full)
`endif
    );

`ifndef CALL_STACK_ERR_EN
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    always #5 clock = ~clock;

    task automatic expect_state(input logic [31:0] t, input logic e, input logic f,
                                input logic o, input logic u, input string tag);
        exp_t x;
        x.top = t; x.emp = e; x.ful = f; x.ovf = o; x.unf = u; x.tag = tag;
        sb_q.push_back(x);
    endtask

    task automatic check_front();
        exp_t x;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_empty got 0 entries expected 1");
        end else begin
            x = sb_q.pop_front();
            n_checks++;
            assert (topStack === x.top) else begin
                n_fail++;
                $error("FAIL %s.top got %0d expected %0d", x.tag, topStack, x.top);
            end
            n_checks++;
            assert (empty === x.emp) else begin
                n_fail++;
                $error("FAIL %s.empty got %b expected %b", x.tag, empty, x.emp);
            end
            n_checks++;
            assert (full === x.ful) else begin
                n_fail++;
                $error("FAIL %s.full got %b expected %b", x.tag, full, x.ful);
            end
`ifdef CALL_STACK_ERR_EN
            n_checks++;
            assert (overflow === x.ovf) else begin
                n_fail++;
                $error("FAIL %s.overflow got %b expected %b", x.tag, overflow, x.ovf);
            end
            n_checks++;
            assert (underflow === x.unf) else begin
                n_fail++;
                $error("FAIL %s.underflow got %b expected %b", x.tag, underflow, x.unf);
            end
`endif
        end
    endtask

    // Drive one request, let one rising edge sample it, then compare 1 ns later.
    task automatic step(input logic en, input logic ps, input logic pp, input logic [31:0] d,
                        input logic [31:0] t, input logic e, input logic f,
                        input logic o, input logic u, input string tag);
        EN = en; push = ps; pop = pp; pushData = d;
        expect_state(t, e, f, o, u, tag);
        @(posedge clock);
        #1;
        EN = 1'b0; push = 1'b0; pop = 1'b0; pushData = 32'd0;
        check_front();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset held for five cycles
        repeat (5) @(posedge clock);
        #1;
        expect_state(32'd0, 1'b1, 1'b0, 1'b0, 1'b0, "reset");
        check_front();
        reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, "idle");

        // Push 5, push 9, pop
        step(1'b1, 1'b1, 1'b0, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, "push5");
        step(1'b1, 1'b1, 1'b0, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 1'b0, "push9");
        step(1'b1, 1'b0, 1'b1, 32'd0, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, "pop_to5");
        step(1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, "pop_to_empty");

        // Fill to DEPTH, then overflow
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'(i), 32'(i), 1'b0, (i == 8), 1'b0, 1'b0, "fill");
        end
        step(1'b1, 1'b1, 1'b0, 32'd99, 32'd8, 1'b0, 1'b1, 1'b1, 1'b0, "push_full");
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, 1'b0, 1'b1, 32'd0, 32'(i), (i == 0), 1'b0, 1'b1, 1'b0, "drain");
        end

        // Underflow, then push still works
        step(1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, "pop_empty");
        step(1'b1, 1'b1, 1'b0, 32'd3, 32'd3, 1'b0, 1'b0, 1'b1, 1'b1, "push3_after_unf");
        step(1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, "pop3");

        // Replace top; depth stays one
        step(1'b1, 1'b1, 1'b0, 32'd7, 32'd7, 1'b0, 1'b0, 1'b1, 1'b1, "push7");
        step(1'b1, 1'b1, 1'b1, 32'd12, 32'd12, 1'b0, 1'b0, 1'b1, 1'b1, "replace12");
        step(1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, "pop_after_replace");

        // Reset clears sticky flags; replace from empty acts as push, no underflow
        do_reset();
        expect_state(32'd0, 1'b1, 1'b0, 1'b0, 1'b0, "reset2");
        check_front();
        step(1'b1, 1'b1, 1'b1, 32'd4, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, "replace_empty4");
        step(1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, "pop4");

        // EN low: erroneous pop sets nothing
        step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, "en0_pop_empty");

        // Build depth 3, then EN low push/pop ignored
        step(1'b1, 1'b1, 1'b0, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, "d1");
        step(1'b1, 1'b1, 1'b0, 32'd6, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0, "d2");
        step(1'b1, 1'b1, 1'b0, 32'd7, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, "d3");
        step(1'b0, 1'b1, 1'b0, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, "en0_push");
        step(1'b0, 1'b0, 1'b1, 32'd0, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, "en0_pop");
        step(1'b1, 1'b0, 1'b1, 32'd0, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0, "pop_after_en0");
        step(1'b1, 1'b1, 1'b0, 32'd8, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0, "d3_again");

        // Asynchronous reset between edges, with a push pending
        #2;
        EN = 1'b1; push = 1'b1; pushData = 32'd42;
        reset_n = 1'b0;
        #1;
        expect_state(32'd0, 1'b1, 1'b0, 1'b0, 1'b0, "async_reset");
        check_front();
        @(posedge clock);
        #1;
        EN = 1'b0; push = 1'b0; pushData = 32'd0;
        reset_n = 1'b1;
        expect_state(32'd0, 1'b1, 1'b0, 1'b0, 1'b0, "push_lost_in_reset");
        check_front();
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, "idle_after_reset");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
